// File: rtl/csa_sub_seq.sv
// rtl/csa_sub_seq.sv - Multi-cycle carry-select subtractor, one CHUNK-bit group per clock
//
// Computes o_diff = i_minuend - i_subtrahend (mod 2^WIDTH) as A + ~B + 1.
// Each group precomputes its sum for carry-in 0 and carry-in 1. A registered
// carry then picks one of the two sums. One group is processed per clock.
//
// Optional feature: define CSA_SUB_OVF_EN to add the o_overflow port and its
// signed-overflow logic.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_valid        operands valid
//   o_ready        block can accept operands (IDLE)
//   i_minuend      A
//   i_subtrahend   B
//   o_valid        result valid (DONE)
//   i_ready        downstream accepts result
//   o_diff         A - B mod 2^WIDTH
//   o_overflow     signed overflow (CSA_SUB_OVF_EN only)
//   o_borrow       1 iff A < B (unsigned)
module csa_sub_seq #(
    parameter int WIDTH = 42,
    parameter int CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
`ifdef CSA_SUB_OVF_EN
    output logic             o_overflow,
`endif
    output logic             o_borrow
);

    localparam int NCHUNK   = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW       = NCHUNK * CHUNK;
    localparam int TOP_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int CW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bn_q, bn_d;     // latched ~B
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef CSA_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Group datapath
    logic [PW-1:0]    a_pad, bn_pad;
    logic [CHUNK-1:0] a_grp, b_grp;
    logic [CHUNK:0]   s0, s1, sel;
    logic             last;
    logic             carry_out;

    // Zero padding above WIDTH keeps the top group's unused bits from
    // disturbing its carry; the carry is taken from bit TOP_BITS there.
    assign a_pad  = PW'(a_q);
    assign bn_pad = PW'(bn_q);
    assign last   = (cnt_q == CW'(NCHUNK - 1));

    always_comb begin
        a_grp = '0;
        b_grp = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                a_grp = a_pad[k*CHUNK +: CHUNK];
                b_grp = bn_pad[k*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        s0        = {1'b0, a_grp} + {1'b0, b_grp};
        s1        = {1'b0, a_grp} + {1'b0, b_grp} + (CHUNK+1)'(1);
        sel       = carry_q ? s1 : s0;
        carry_out = last ? sel[TOP_BITS] : sel[CHUNK];
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            bn_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef CSA_SUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            bn_q     <= bn_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef CSA_SUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath register updates
    always_comb begin
        a_d      = a_q;
        bn_d     = bn_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef CSA_SUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_minuend;
                    bn_d    = ~i_subtrahend;
                    cnt_d   = '0;
                    carry_d = 1'b1;   // the "+1" of A + ~B + 1
                    diff_d  = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CW'(i / CHUNK)) begin
                        diff_d[i] = sel[i % CHUNK];
                    end
                end
                carry_d = carry_out;
                // Counter parks on the last group; only a new accept clears it.
                if (!last) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (last) begin
                    borrow_d = ~carry_out;
`ifdef CSA_SUB_OVF_EN
                    ovf_d = (a_q[WIDTH-1] != ~bn_q[WIDTH-1]) &&
                            (diff_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        o_ready    = (state_q == IDLE);
        o_valid    = (state_q == DONE);
        o_diff     = diff_q;
        o_borrow   = borrow_q;
`ifdef CSA_SUB_OVF_EN
        o_overflow = ovf_q;
`endif
    end

endmodule

// File: tb/tb_csa_sub_seq.sv
// tb/tb_csa_sub_seq.sv - Scoreboard testbench for csa_sub_seq
module tb_csa_sub_seq;

    localparam int W = 42;

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_minuend;
    logic [W-1:0] i_subtrahend;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_overflow;

    csa_sub_seq #(.WIDTH(W), .CHUNK(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_minuend    (i_minuend),
        .i_subtrahend (i_subtrahend),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_diff       (o_diff),
`ifdef CSA_SUB_OVF_EN
        .o_overflow   (o_overflow),
`endif
        .o_borrow     (o_borrow)
    );

`ifndef CSA_SUB_OVF_EN
    assign o_overflow = 1'b0;
`endif

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.d = a - b;
        e.b = (a < b);
        e.v = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        check("ready_before_accept", o_ready, 1);
    endtask

    // Issue one transaction, check latency, optional backpressure, result.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
        int    lat;
        exp_t  e;
        logic [W-1:0] d_hold;
        logic  b_hold;
        wait_ready();
        i_valid      = 1'b1;
        i_minuend    = a;
        i_subtrahend = b;
        sb.push_back(model(a, b));
        @(posedge i_clk); #1;
        i_valid      = 1'b0;
        i_minuend    = rnd();
        i_subtrahend = rnd();
        check("ready_low_in_run", o_ready, 0);
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(posedge i_clk); #1;
            lat++;
        end
        check("latency", lat, 11);
        d_hold = o_diff;
        b_hold = o_borrow;
        if (bp > 0) begin
            i_valid = 1'b1;
            for (int c = 0; c < bp; c++) begin
                i_minuend    = rnd();
                i_subtrahend = rnd();
                @(posedge i_clk); #1;
                check("bp_valid", o_valid, 1);
                check("bp_ready", o_ready, 0);
                check("bp_diff",  o_diff, d_hold);
                check("bp_borrow", o_borrow, b_hold);
            end
        end
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("diff", o_diff, e.d);
            check("borrow", o_borrow, e.b);
`ifdef CSA_SUB_OVF_EN
            check("overflow", o_overflow, e.v);
`endif
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        i_valid = 1'b0;
        check("valid_drop", o_valid, 0);
        check("ready_back", o_ready, 1);
        if (bp > 0) begin
            @(posedge i_clk); #1;
            check("no_accept_after_bp", o_ready, 1);
            check("diff_kept", o_diff, d_hold);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_minuend    = '0;
        i_subtrahend = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_diff", o_diff, 0);
        check("rst_borrow", o_borrow, 0);
        check("rst_ovf", o_overflow, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        run_txn(42'h00000000005, 42'h00000000003, 0);
        run_txn(42'h00000000000, 42'h00000000001, 0);
        run_txn(42'h2AAAAAAAAAA, 42'h2AAAAAAAAAA, 0);
        run_txn(42'h15555555555, 42'h2AAAAAAAAAA, 0);
        run_txn(42'h00000000000, 42'h3FFFFFFFFFF, 0);
        run_txn(42'h3FFFFFFFFFF, 42'h00000000000, 5);
        run_txn(42'h20000000000, 42'h00000000001, 0);
        run_txn(42'h1FFFFFFFFFF, 42'h3FFFFFFFFFF, 0);
        for (int t = 0; t < 6; t++) run_txn(rnd(), rnd(), (t == 2) ? 3 : 0);

        // Reset in the middle of RUN (counter = 5).
        wait_ready();
        i_valid      = 1'b1;
        i_minuend    = 42'h123456789AB;
        i_subtrahend = 42'h0000000FFFF;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("midrst_ready", o_ready, 1);
        check("midrst_valid", o_valid, 0);
        check("midrst_diff", o_diff, 0);
        check("midrst_borrow", o_borrow, 0);
        check("midrst_ovf", o_overflow, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_txn(42'd7, 42'd2, 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
